cdr_sample_timer: RTL and testbench

//  Symbol-period timer for the CDR loop. Counts one symbol period and emits single-cycle

---
 rtl/cdr_sample_timer.sv | 97 +++++++++
 tb/tb_cdr_sample_timer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cdr_sample_timer.sv
// Symbol-period timer for the CDR loop: one counter per symbol, registered single-cycle
// sampling/capture/wrap strobes, shadowed period and one-clock phase stretch/shrink.
module cdr_sample_timer #(
  parameter int CNT_W      = 6,
  parameter int SYM_W      = 16,
  parameter int MIN_PERIOD = 8,
  parameter int DEF_PERIOD = 25
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_nb_P,
  input  logic [1:0]       i_phase_adj,
  output logic             o_en_d,
  output logic             o_en_m,
  output logic             o_en_f,
  output logic             o_en,
  output logic             o_en_freq_synch,
  output logic             o_wrap,
  output logic [CNT_W-1:0] o_phase,
  output logic [CNT_W-1:0] o_period,
  output logic [SYM_W-1:0] o_sym_cnt
);

  localparam logic [1:0] ADJ_NONE    = 2'b00;
  localparam logic [1:0] ADJ_RETARD  = 2'b01;
  localparam logic [1:0] ADJ_ADVANCE = 2'b10;

  logic [CNT_W-1:0] cnt, per, pc;
  logic [CNT_W-1:0] pos_m, pos_f, pos_e, pos_s, pos_w;
  logic [1:0]       adj_q;
  logic             hold;
  logic             at_w, stretch;

  assign pc = (i_nb_P < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : i_nb_P;

  // Positions derive from the active period only, so a new i_nb_P waits for the wrap.
  assign pos_m = ((per - CNT_W'(1)) >> 1) - CNT_W'(1);
  assign pos_f = per - CNT_W'(4);
  assign pos_e = per - CNT_W'(3);
  assign pos_s = per - CNT_W'(2);
  assign pos_w = per - CNT_W'(1);

  assign at_w    = (cnt == pos_w);
  assign stretch = at_w && (adj_q == ADJ_RETARD) && !hold;

  assign o_phase  = cnt;
  assign o_period = per;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt             <= '0;
      per             <= CNT_W'(DEF_PERIOD);
      adj_q           <= ADJ_NONE;
      hold            <= 1'b0;
      o_sym_cnt       <= '0;
      o_en_d          <= 1'b0;
      o_en_m          <= 1'b0;
      o_en_f          <= 1'b0;
      o_en            <= 1'b0;
      o_en_freq_synch <= 1'b0;
      o_wrap          <= 1'b0;
    end else if (!i_run) begin
      cnt             <= '0;
      per             <= pc;
      adj_q           <= ADJ_NONE;
      hold            <= 1'b0;
      o_en_d          <= 1'b0;
      o_en_m          <= 1'b0;
      o_en_f          <= 1'b0;
      o_en            <= 1'b0;
      o_en_freq_synch <= 1'b0;
      o_wrap          <= 1'b0;
    end else begin
      o_en_d          <= (cnt == CNT_W'(1));
      o_en_m          <= (cnt == pos_m);
      o_en_f          <= (cnt == pos_f);
      o_en            <= (cnt == pos_e);
      o_en_freq_synch <= (cnt == pos_s);
      // A stretched symbol wraps only after its second W cycle.
      o_wrap          <= at_w && !stretch;
      if (cnt == pos_s) adj_q <= i_phase_adj;
      if (stretch) begin
        hold <= 1'b1;
      end else if (at_w) begin
        cnt       <= (adj_q == ADJ_ADVANCE) ? CNT_W'(1) : '0;
        per       <= pc;
        o_sym_cnt <= o_sym_cnt + SYM_W'(1);
        adj_q     <= ADJ_NONE;
        hold      <= 1'b0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cdr_sample_timer.sv
// Directed bench for cdr_sample_timer: walks reset, period reload, phase adjust,
// clamping, run abort and mid-period reset with hand-computed strobe positions.
module tb_cdr_sample_timer;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_run;
  logic [5:0] i_nb_P;
  logic [1:0] i_phase_adj;
  logic       o_en_d, o_en_m, o_en_f, o_en, o_en_freq_synch, o_wrap;
  logic [5:0] o_phase, o_period;
  logic [1:0] o_sym_cnt;

  int checks = 0;
  int errors = 0;

  cdr_sample_timer #(.CNT_W(6), .SYM_W(2), .MIN_PERIOD(8), .DEF_PERIOD(25)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_run(i_run), .i_nb_P(i_nb_P),
    .i_phase_adj(i_phase_adj), .o_en_d(o_en_d), .o_en_m(o_en_m), .o_en_f(o_en_f),
    .o_en(o_en), .o_en_freq_synch(o_en_freq_synch), .o_wrap(o_wrap),
    .o_phase(o_phase), .o_period(o_period), .o_sym_cnt(o_sym_cnt)
  );

  always #5 i_clk = ~i_clk;

  logic [5:0] stb;
  assign stb = {o_en_d, o_en_m, o_en_f, o_en, o_en_freq_synch, o_wrap};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Steps from counter value 'from' up to 'to'; c is the count seen at each edge.
  task automatic span(input string tag, input int from, input int to, input int pd,
                      input int d, input int m, input int f, input int e,
                      input int s, input int w);
    for (int c = from; c < to; c++) begin
      step();
      chk($sformatf("%s.phase@%0d", tag, c), 32'(o_phase), 32'((c + 1) % pd));
      chk($sformatf("%s.stb@%0d", tag, c), 32'(stb),
          32'({c == d, c == m, c == f, c == e, c == s, c == w}));
    end
  endtask

  task automatic span25(input string tag, input int from, input int to);
    span(tag, from, to, 25, 1, 11, 21, 22, 23, 24);
  endtask

  task automatic span16(input string tag, input int from, input int to);
    span(tag, from, to, 16, 1, 6, 12, 13, 14, 15);
  endtask

  task automatic span8(input string tag, input int from, input int to);
    span(tag, from, to, 8, 1, 2, 4, 5, 6, 7);
  endtask

  task automatic chk_idle(input string tag, input int sym, input int per);
    chk({tag, ".phase"}, 32'(o_phase), 32'(0));
    chk({tag, ".stb"}, 32'(stb), 32'(0));
    chk({tag, ".sym"}, 32'(o_sym_cnt), 32'(sym));
    chk({tag, ".period"}, 32'(o_period), 32'(per));
  endtask

  initial begin
    i_rst = 1'b0; i_run = 1'b0; i_nb_P = 6'd25; i_phase_adj = 2'b00;
    step(); step();
    chk_idle("reset", 0, 25);

    // 1: default period, strobes at 1,11,21,22,23,24
    i_rst = 1'b1; i_run = 1'b1;
    span25("t1", 0, 25);
    chk("t1.sym", 32'(o_sym_cnt), 32'(1));

    // 2: period change mid-symbol applies at the wrap
    span25("t2a", 0, 5);
    i_nb_P = 6'd16;
    span25("t2b", 5, 25);
    chk("t2.sym", 32'(o_sym_cnt), 32'(2));
    chk("t2.period", 32'(o_period), 32'(16));
    i_nb_P = 6'd25;
    span16("t2c", 0, 16);
    chk("t2.sym3", 32'(o_sym_cnt), 32'(3));
    chk("t2.period25", 32'(o_period), 32'(25));

    // 3a: retard -> 26-clock symbol, single wrap, sym counter 3->0
    span25("t3r", 0, 23);
    i_phase_adj = 2'b01;
    step();
    chk("t3r.phase_w", 32'(o_phase), 32'(24));
    chk("t3r.stb_s", 32'(stb), 32'(6'b000010));
    i_phase_adj = 2'b00;
    step();
    chk("t3r.phase_hold", 32'(o_phase), 32'(24));
    chk("t3r.stb_hold", 32'(stb), 32'(0));
    chk("t3r.sym_hold", 32'(o_sym_cnt), 32'(3));
    step();
    chk("t3r.phase_wrap", 32'(o_phase), 32'(0));
    chk("t3r.stb_wrap", 32'(stb), 32'(6'b000001));
    chk("t3r.sym_wrap", 32'(o_sym_cnt), 32'(0));

    // 3b: advance -> restart at 1; adjust held outside S is ignored
    span25("t3a", 0, 23);
    i_phase_adj = 2'b10;
    step();
    chk("t3a.stb_s", 32'(stb), 32'(6'b000010));
    i_phase_adj = 2'b01;
    step();
    chk("t3a.phase_adv", 32'(o_phase), 32'(1));
    chk("t3a.stb_wrap", 32'(stb), 32'(6'b000001));
    chk("t3a.sym", 32'(o_sym_cnt), 32'(1));
    step();
    chk("t3a.phase2", 32'(o_phase), 32'(2));
    chk("t3a.en_d", 32'(stb), 32'(6'b100000));
    span25("t3b", 2, 22);
    i_phase_adj = 2'b00;
    span25("t3c", 22, 25);
    chk("t3c.sym", 32'(o_sym_cnt), 32'(2));

    // 4: undersized period clamps to 8
    i_nb_P = 6'd3;
    span25("t4a", 0, 25);
    chk("t4.period", 32'(o_period), 32'(8));
    chk("t4.sym", 32'(o_sym_cnt), 32'(3));
    i_nb_P = 6'd25;
    span8("t4b", 0, 8);
    chk("t4.sym0", 32'(o_sym_cnt), 32'(0));
    chk("t4.period25", 32'(o_period), 32'(25));

    // 5a: run drop at cnt=10 aborts the symbol; P follows i_nb_P while idle
    i_phase_adj = 2'b01;
    span25("t5a", 0, 10);
    i_run = 1'b0; i_nb_P = 6'd16;
    step();
    chk_idle("t5.idle1", 0, 16);
    step();
    chk_idle("t5.idle2", 0, 16);
    i_run = 1'b1; i_phase_adj = 2'b00; i_nb_P = 6'd25;
    span16("t5b", 0, 16);
    chk("t5b.sym", 32'(o_sym_cnt), 32'(1));
    chk("t5b.period", 32'(o_period), 32'(25));

    // 5b: run drop with retard latched discards the retard
    span25("t5c", 0, 23);
    i_phase_adj = 2'b01;
    step();
    chk("t5c.stb_s", 32'(stb), 32'(6'b000010));
    i_phase_adj = 2'b00; i_run = 1'b0;
    step();
    chk_idle("t5.abort", 1, 25);
    i_run = 1'b1;
    span25("t5d", 0, 25);
    chk("t5d.sym", 32'(o_sym_cnt), 32'(2));

    // 6: reset mid-period restores defaults regardless of i_nb_P
    span25("t6a", 0, 17);
    i_nb_P = 6'd16; i_rst = 1'b0;
    step();
    chk_idle("t6.reset", 0, 25);
    i_rst = 1'b1;
    span25("t6b", 0, 25);
    chk("t6.sym", 32'(o_sym_cnt), 32'(1));
    chk("t6.period", 32'(o_period), 32'(16));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
